// File: rtl/led_pio_sequencer.sv
// Autonomous LED pattern engine: Avalon-MM slave for CPU setup, Avalon-MM master for timed PIO writes.
// Optional interrupt support is enabled by defining LED_SEQ_IRQ_EN.
module led_pio_sequencer #(
    parameter int LED_W  = 8,
    parameter int DIV_W  = 24,
    parameter int NSTEPS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
`ifdef LED_SEQ_IRQ_EN
    output logic        irq,
`endif
    input  logic        m_waitrequest
);

    localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    state_t              state;
    logic                ctrl_enable;
    logic                ctrl_oneshot;
    logic                ctrl_irq_en;
    logic                done;
    logic [DIV_W-1:0]    div_reg;
    logic [DIV_W-1:0]    div_cnt;
    logic [STEP_W-1:0]   step;
    logic [LED_W-1:0]    pattern [NSTEPS];

    logic                wr_en, wr_ctrl, wr_div, wr_status, wr_pat;
    logic                enable_nxt;
    logic                last_step;
    logic [STEP_W-1:0]   step_nxt;
    logic [STEP_W-1:0]   pat_idx;
    logic [DIV_W-1:0]    div_load;
    logic                unused_wdata;

    assign wr_en      = s_chipselect & ~s_write_n;
    assign wr_ctrl    = wr_en && (s_address == 4'd0);
    assign wr_div     = wr_en && (s_address == 4'd1);
    assign wr_status  = wr_en && (s_address == 4'd2);
    assign pat_idx    = s_address[STEP_W-1:0];
    assign wr_pat     = wr_en && s_address[3] && (int'(s_address[2:0]) < NSTEPS);
    // The FSM reacts to the enable value being written this cycle, so a start costs no extra cycle.
    assign enable_nxt = wr_ctrl ? s_writedata[0] : ctrl_enable;
    assign step_nxt   = step + STEP_W'(1);
    assign last_step  = (step == STEP_W'(NSTEPS - 1));
    assign div_load   = (div_reg == '0) ? '0 : div_reg - DIV_W'(1);
    assign m_address  = 2'b00;
    assign unused_wdata = ^s_writedata;

`ifdef LED_SEQ_IRQ_EN
    assign irq = done & ctrl_irq_en;
`endif

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0: begin
                s_readdata[0] = ctrl_enable;
                s_readdata[1] = ctrl_oneshot;
`ifdef LED_SEQ_IRQ_EN
                s_readdata[2] = ctrl_irq_en;
`endif
            end
            4'd1: s_readdata[DIV_W-1:0] = div_reg;
            4'd2: begin
                s_readdata[0]             = (state != IDLE);
                s_readdata[4 +: STEP_W]   = step;
                s_readdata[8]             = done;
            end
            default: begin
                if (s_address[3] && (int'(s_address[2:0]) < NSTEPS))
                    s_readdata[LED_W-1:0] = pattern[pat_idx];
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments only, so every read below sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ctrl_enable  <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            done         <= 1'b0;
            div_reg      <= '0;
            div_cnt      <= '0;
            step         <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
            // NOTE: the pattern file is small and software-visible, so it is reset with everything else.
            for (int i = 0; i < NSTEPS; i++) pattern[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable  <= s_writedata[0];
                ctrl_oneshot <= s_writedata[1];
`ifdef LED_SEQ_IRQ_EN
                ctrl_irq_en  <= s_writedata[2];
`endif
            end
            if (wr_div) div_reg <= s_writedata[DIV_W-1:0];
            if (wr_status && s_writedata[8]) done <= 1'b0;
            if (wr_pat) pattern[pat_idx] <= s_writedata[LED_W-1:0];

            case (state)
                IDLE: begin
                    if (enable_nxt) begin
                        m_writedata  <= 32'(pattern[step]);
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    // An in-flight write always completes, whatever the CPU does to CTRL.
                    if (!m_waitrequest) begin
                        m_chipselect <= 1'b0;
                        m_write_n    <= 1'b1;
                        div_cnt      <= div_load;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end else if (!enable_nxt) begin
                        step  <= '0;
                        state <= IDLE;
                    end else if (ctrl_oneshot && last_step) begin
                        ctrl_enable  <= 1'b0;
                        ctrl_oneshot <= 1'b0;
                        done         <= 1'b1;
                        step         <= '0;
                        state        <= IDLE;
                    end else begin
`ifdef LED_SEQ_IRQ_EN
                        if (last_step) done <= 1'b1;
`endif
                        step         <= step_nxt;
                        m_writedata  <= 32'(pattern[step_nxt]);
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        state        <= WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Scoreboard bench for led_pio_sequencer: stimulus queues expected master writes, a monitor checks them.
module tb_led_pio_sequencer;

`ifdef LED_SEQ_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
`ifdef LED_SEQ_IRQ_EN
    logic        irq;
`endif

    led_pio_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
`ifdef LED_SEQ_IRQ_EN
        .irq          (irq),
`endif
        .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         gap;   // cycles since previous accepted write; 0 = first write of a run
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   run_start = 0;
    int   last_acc = 0;
    int   acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_wr(input logic [7:0] d, input int gap);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        sb_q.push_back(e);
    endtask

    task automatic cpu_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        s_address    = addr;
        s_writedata  = data;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        if (addr == 4'd0) run_start = cyc + 1;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic cpu_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        s_address    = addr;
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        #1;
        data = s_readdata;
        s_chipselect = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        cpu_read(addr, d);
        check(name, d, exp);
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (acc_cnt < n && k < 200);
        if (acc_cnt < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_acc timeout: got %0d writes expected %0d", acc_cnt, n);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain timeout: %0d writes outstanding expected 0", sb_q.size());
        end
    endtask

    // Monitor: compares every master write the DUT presents against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (m_chipselect && !m_write_n) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                acc_cnt = acc_cnt + (m_waitrequest ? 0 : 1);
                $display("FAIL unexpected_write: got data 0x%08h expected no write (cycle %0d)",
                         m_writedata, cyc);
            end else if (m_waitrequest) begin
                check("stall_data", m_writedata, {24'h0, sb_q[0].data});
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wr_data", m_writedata, {24'h0, e.data});
                check("wr_addr", {30'h0, m_address}, 32'h0);
                check("wr_cycle", cyc, (e.gap == 0) ? run_start : last_acc + e.gap);
                last_acc = cyc;
                acc_cnt  = acc_cnt + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] cont_pat [4];
        cont_pat = '{8'h01, 8'h02, 8'h04, 8'h08};

        repeat (3) @(negedge clk);
        check("rst_write_n", {31'h0, m_write_n}, 32'h1);
        check("rst_chipselect", {31'h0, m_chipselect}, 32'h0);
        check("rst_wdata", m_writedata, 32'h0);
        reset_n = 1'b1;
        read_check("rst_ctrl", 4'd0, 32'h0);
        read_check("rst_div", 4'd1, 32'h0);
        read_check("rst_status", 4'd2, 32'h0);
        read_check("rst_pat0", 4'd8, 32'h0);
        read_check("rst_unused", 4'd15, 32'h0);

        // Continuous run, DIV=3 -> strobes 4 cycles apart.
        for (int i = 0; i < 4; i++) cpu_write(4'(8 + i), {24'h0, cont_pat[i]});
        cpu_write(4'd12, 32'h77);
        read_check("unmapped_read", 4'd12, 32'h0);
        read_check("pat2_readback", 4'd10, 32'h04);
        cpu_write(4'd1, 32'h3);
        read_check("div_readback", 4'd1, 32'h3);
        exp_wr(8'h01, 0); exp_wr(8'h02, 4); exp_wr(8'h04, 4); exp_wr(8'h08, 4); exp_wr(8'h01, 4);
        base = acc_cnt;
        cpu_write(4'd0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            wait_acc(base + k);
            read_check("cont_status", 4'd2,
                       (k == 5) ? (32'h1 | (IRQ_BUILD ? 32'h100 : 32'h0))
                                : (32'h1 | 32'((k - 1) << 4)));
        end
        cpu_write(4'd0, 32'h0);
        wait_drain();
        repeat (6) @(negedge clk);
        read_check("cont_idle_status", 4'd2, IRQ_BUILD ? 32'h100 : 32'h0);
        cpu_write(4'd2, 32'h100);

        // Oneshot run, DIV=0 -> treated as 1, strobes 2 cycles apart.
        cpu_write(4'd8, 32'hAA); cpu_write(4'd9, 32'h55);
        cpu_write(4'd10, 32'hFF); cpu_write(4'd11, 32'h00);
        cpu_write(4'd1, 32'h0);
        exp_wr(8'hAA, 0); exp_wr(8'h55, 2); exp_wr(8'hFF, 2); exp_wr(8'h00, 2);
        cpu_write(4'd0, 32'h3);
        wait_drain();
        repeat (8) @(negedge clk);
        read_check("oneshot_ctrl", 4'd0, 32'h0);
        read_check("oneshot_status", 4'd2, 32'h100);
        cpu_write(4'd2, 32'h100);
        read_check("done_cleared", 4'd2, 32'h0);

        // Stall the second write for 5 cycles, DIV=2.
        cpu_write(4'd1, 32'h2);
        exp_wr(8'hAA, 0); exp_wr(8'h55, 3 + 5); exp_wr(8'hFF, 3);
        base = acc_cnt;
        cpu_write(4'd0, 32'h1);
        wait_acc(base + 1);
        m_waitrequest = 1'b1;
        begin
            int n = 0;
            int k = 0;
            while (n < 5 && k < 100) begin
                @(negedge clk);
                #1;
                if (m_chipselect && !m_write_n) n++;
                k++;
            end
            check("stall_cycles", n, 5);
        end
        @(negedge clk);
        m_waitrequest = 1'b0;
        wait_acc(base + 3);
        cpu_write(4'd0, 32'h0);
        wait_drain();
        repeat (6) @(negedge clk);
        read_check("stall_idle_status", 4'd2, 32'h0);

        // Disable in the 2nd cycle of a DIV=9 hold.
        cpu_write(4'd1, 32'h9);
        exp_wr(8'hAA, 0);
        base = acc_cnt;
        cpu_write(4'd0, 32'h1);
        wait_acc(base + 1);
        cpu_write(4'd0, 32'h0);
        read_check("dis_hold_busy", 4'd2, 32'h1);
        repeat (12) @(negedge clk);
        read_check("dis_idle_status", 4'd2, 32'h0);
        check("dis_write_count", acc_cnt, base + 1);

`ifdef LED_SEQ_IRQ_EN
        // Continuous with irq_en, DIV=3: irq rises on the first wrap.
        for (int i = 0; i < 4; i++) cpu_write(4'(8 + i), {24'h0, cont_pat[i]});
        cpu_write(4'd1, 32'h3);
        exp_wr(8'h01, 0); exp_wr(8'h02, 4); exp_wr(8'h04, 4); exp_wr(8'h08, 4);
        exp_wr(8'h01, 4); exp_wr(8'h02, 4);
        base = acc_cnt;
        cpu_write(4'd0, 32'h5);
        read_check("irq_ctrl", 4'd0, 32'h5);
        wait_acc(base + 4);
        check("irq_before_wrap", {31'h0, irq}, 32'h0);
        wait_acc(base + 5);
        check("irq_after_wrap", {31'h0, irq}, 32'h1);
        cpu_write(4'd2, 32'h100);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        cpu_write(4'd0, 32'h0);
        wait_drain();
        repeat (8) @(negedge clk);
        read_check("irq_idle_status", 4'd2, 32'h0);
`endif

        repeat (4) @(negedge clk);
        check("queue_empty", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
